// File: rtl/color_tracker_pkg.sv
// color_tracker_pkg
// Shared types and constants for the colour tracker: the frame FSM state
// encoding, the overlay colour and a packed bundle of one VGA pixel with its
// timing bits.
package color_tracker_pkg;

    typedef enum logic [0:0] {
        WAIT_VS = 1'b0,
        ACCUM   = 1'b1
    } state_e;

    localparam logic [7:0] OVL_R = 8'd0;
    localparam logic [7:0] OVL_G = 8'd255;
    localparam logic [7:0] OVL_B = 8'd0;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       hs;
        logic       vs;
        logic       sync_n;
        logic       blank_n;
    } vga_px_t;

    // Sync lines idle high; everything else idles low.
    localparam vga_px_t PX_RST = '{
        r: 8'd0, g: 8'd0, b: 8'd0,
        hs: 1'b1, vs: 1'b1, sync_n: 1'b0, blank_n: 1'b0
    };

endpackage

// File: rtl/vga_pos_counter.sv
// vga_pos_counter
// Tracks the raster position of the incoming pixel from the blanking and
// vertical sync strobes.
//   clk_i, rst_i     pixel clock, async active-high reset
//   blank_n_i, vs_i  incoming timing bits
//   x_o, y_o         position of the pixel currently on the inputs
//   in_range_o       position lies inside WIDTH x HEIGHT
//   line_end_o       BLANK_N falling edge (end of an active line)
//   vs_fall_o        VS falling edge (start of vertical sync)
module vga_pos_counter #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int XW     = $clog2(WIDTH),
    parameter int YW     = $clog2(HEIGHT)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          blank_n_i,
    input  logic          vs_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          in_range_o,
    output logic          line_end_o,
    output logic          vs_fall_o
);

    // One spare bit so pixels beyond the nominal line/frame (controller
    // off-by-one) never alias back into the valid range.
    localparam logic [XW:0] X_LIM = (XW+1)'(WIDTH);
    localparam logic [YW:0] Y_LIM = (YW+1)'(HEIGHT);

    logic [XW:0] x_q, x_d;
    logic [YW:0] y_q, y_d;
    logic        blank_q;
    logic        vs_q;

    assign line_end_o = blank_q & ~blank_n_i;
    assign vs_fall_o  = vs_q & ~vs_i;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (!vs_i) begin
            x_d = '0;
            y_d = '0;
        end else if (line_end_o) begin
            x_d = '0;
            if (y_q != '1) begin
                y_d = y_q + 1'b1;
            end
        end else if (blank_n_i && (x_q != '1)) begin
            x_d = x_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_q     <= '0;
            y_q     <= '0;
            blank_q <= 1'b0;
            vs_q    <= 1'b1;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            blank_q <= blank_n_i;
            vs_q    <= vs_i;
        end
    end

    assign x_o        = x_q[XW-1:0];
    assign y_o        = y_q[YW-1:0];
    assign in_range_o = (x_q < X_LIM) && (y_q < Y_LIM);

endmodule

// File: rtl/color_tracker.sv
// color_tracker
// Classifies active pixels against RGB thresholds, accumulates a per-frame
// match count and bounding box, publishes them at the start of vertical sync
// and forwards the stream one cycle later with an optional box overlay.
//   VGA_CLK, reset             pixel clock, async active-high reset
//   iVGA_*                     filtered input stream
//   r_min, g_max, b_max        inclusive colour thresholds
//   overlay_en                 draw the published box on the output
//   oVGA_*                     registered output stream
//   box_*, match_count,
//   detected, frame_done       published per-frame results
//
// state   | meaning
// --------+-------------------------------------------------------------
// WAIT_VS | after reset; the next VS fall starts the first counted frame
// ACCUM   | accumulating; each VS fall publishes and restarts the frame
module color_tracker
    import color_tracker_pkg::*;
#(
    parameter  int WIDTH     = 640,
    parameter  int HEIGHT    = 480,
    parameter  int MIN_COUNT = 64,
    localparam int XW        = $clog2(WIDTH),
    localparam int YW        = $clog2(HEIGHT),
    localparam int CW        = $clog2(WIDTH*HEIGHT+1)
) (
    input  logic          VGA_CLK,
    input  logic          reset,
    input  logic [7:0]    iVGA_R,
    input  logic [7:0]    iVGA_G,
    input  logic [7:0]    iVGA_B,
    input  logic          iVGA_HS,
    input  logic          iVGA_VS,
    input  logic          iVGA_SYNC_N,
    input  logic          iVGA_BLANK_N,
    input  logic [7:0]    r_min,
    input  logic [7:0]    g_max,
    input  logic [7:0]    b_max,
    input  logic          overlay_en,
    output logic [7:0]    oVGA_R,
    output logic [7:0]    oVGA_G,
    output logic [7:0]    oVGA_B,
    output logic          oVGA_HS,
    output logic          oVGA_VS,
    output logic          oVGA_SYNC_N,
    output logic          oVGA_BLANK_N,
    output logic [XW-1:0] box_x0,
    output logic [XW-1:0] box_x1,
    output logic [YW-1:0] box_y0,
    output logic [YW-1:0] box_y1,
    output logic [CW-1:0] match_count,
    output logic          detected,
    output logic          frame_done
);

    localparam logic [CW:0] MIN_C = (CW+1)'(MIN_COUNT);

    logic [XW-1:0] pos_x;
    logic [YW-1:0] pos_y;
    logic          in_range;
    logic          vs_fall;
    logic          unused_line_end;

    vga_pos_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .XW     (XW),
        .YW     (YW)
    ) u_pos (
        .clk_i      (VGA_CLK),
        .rst_i      (reset),
        .blank_n_i  (iVGA_BLANK_N),
        .vs_i       (iVGA_VS),
        .x_o        (pos_x),
        .y_o        (pos_y),
        .in_range_o (in_range),
        .line_end_o (unused_line_end),
        .vs_fall_o  (vs_fall)
    );

    vga_px_t px_in, px_d, px_q;
    assign px_in = '{
        r: iVGA_R, g: iVGA_G, b: iVGA_B,
        hs: iVGA_HS, vs: iVGA_VS, sync_n: iVGA_SYNC_N, blank_n: iVGA_BLANK_N
    };

    logic match;
    assign match = iVGA_BLANK_N && in_range &&
                   (iVGA_R >= r_min) && (iVGA_G <= g_max) && (iVGA_B <= b_max);

    state_e        state_q, state_d;
    logic [CW-1:0] acc_cnt_q, acc_cnt_d;
    logic [XW-1:0] acc_x0_q, acc_x0_d, acc_x1_q, acc_x1_d;
    logic [YW-1:0] acc_y0_q, acc_y0_d, acc_y1_q, acc_y1_d;

    logic [CW-1:0] pub_cnt_q, pub_cnt_d;
    logic          pub_det_q, pub_det_d;
    logic [XW-1:0] pub_x0_q, pub_x0_d, pub_x1_q, pub_x1_d;
    logic [YW-1:0] pub_y0_q, pub_y0_d, pub_y1_q, pub_y1_d;
    logic          frame_done_q, frame_done_d;

    logic det_now;
    assign det_now = {1'b0, acc_cnt_q} >= MIN_C;

    // The count never wraps, so a zero count doubles as "no match yet".
    always_comb begin
        acc_cnt_d = acc_cnt_q;
        acc_x0_d  = acc_x0_q;
        acc_x1_d  = acc_x1_q;
        acc_y0_d  = acc_y0_q;
        acc_y1_d  = acc_y1_q;
        if (vs_fall) begin
            acc_cnt_d = '0;
            acc_x0_d  = '0;
            acc_x1_d  = '0;
            acc_y0_d  = '0;
            acc_y1_d  = '0;
        end else if (match) begin
            if (acc_cnt_q != '1) begin
                acc_cnt_d = acc_cnt_q + 1'b1;
            end
            if (acc_cnt_q == '0) begin
                acc_x0_d = pos_x;
                acc_x1_d = pos_x;
                acc_y0_d = pos_y;
                acc_y1_d = pos_y;
            end else begin
                if (pos_x < acc_x0_q) acc_x0_d = pos_x;
                if (pos_x > acc_x1_q) acc_x1_d = pos_x;
                if (pos_y < acc_y0_q) acc_y0_d = pos_y;
                if (pos_y > acc_y1_q) acc_y1_d = pos_y;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        pub_cnt_d    = pub_cnt_q;
        pub_det_d    = pub_det_q;
        pub_x0_d     = pub_x0_q;
        pub_x1_d     = pub_x1_q;
        pub_y0_d     = pub_y0_q;
        pub_y1_d     = pub_y1_q;
        frame_done_d = 1'b0;
        if (vs_fall) begin
            state_d = ACCUM;
            if (state_q == ACCUM) begin
                frame_done_d = 1'b1;
                pub_cnt_d    = acc_cnt_q;
                pub_det_d    = det_now;
                pub_x0_d     = det_now ? acc_x0_q : '0;
                pub_x1_d     = det_now ? acc_x1_q : '0;
                pub_y0_d     = det_now ? acc_y0_q : '0;
                pub_y1_d     = det_now ? acc_y1_q : '0;
            end
        end
    end

    logic x_edge, y_edge, x_inside, y_inside, on_box;
    always_comb begin
        x_edge   = (pos_x == pub_x0_q) || (pos_x == pub_x1_q);
        y_edge   = (pos_y == pub_y0_q) || (pos_y == pub_y1_q);
        x_inside = (pos_x >= pub_x0_q) && (pos_x <= pub_x1_q);
        y_inside = (pos_y >= pub_y0_q) && (pos_y <= pub_y1_q);
        // in_range keeps truncated overshoot positions off the box.
        on_box   = in_range && ((x_edge && y_inside) || (y_edge && x_inside));
        px_d     = px_in;
        if (overlay_en && pub_det_q && iVGA_BLANK_N && on_box) begin
            px_d.r = OVL_R;
            px_d.g = OVL_G;
            px_d.b = OVL_B;
        end
    end

    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) begin
            state_q      <= WAIT_VS;
            acc_cnt_q    <= '0;
            acc_x0_q     <= '0;
            acc_x1_q     <= '0;
            acc_y0_q     <= '0;
            acc_y1_q     <= '0;
            pub_cnt_q    <= '0;
            pub_det_q    <= 1'b0;
            pub_x0_q     <= '0;
            pub_x1_q     <= '0;
            pub_y0_q     <= '0;
            pub_y1_q     <= '0;
            frame_done_q <= 1'b0;
            px_q         <= PX_RST;
        end else begin
            state_q      <= state_d;
            acc_cnt_q    <= acc_cnt_d;
            acc_x0_q     <= acc_x0_d;
            acc_x1_q     <= acc_x1_d;
            acc_y0_q     <= acc_y0_d;
            acc_y1_q     <= acc_y1_d;
            pub_cnt_q    <= pub_cnt_d;
            pub_det_q    <= pub_det_d;
            pub_x0_q     <= pub_x0_d;
            pub_x1_q     <= pub_x1_d;
            pub_y0_q     <= pub_y0_d;
            pub_y1_q     <= pub_y1_d;
            frame_done_q <= frame_done_d;
            px_q         <= px_d;
        end
    end

    assign oVGA_R       = px_q.r;
    assign oVGA_G       = px_q.g;
    assign oVGA_B       = px_q.b;
    assign oVGA_HS      = px_q.hs;
    assign oVGA_VS      = px_q.vs;
    assign oVGA_SYNC_N  = px_q.sync_n;
    assign oVGA_BLANK_N = px_q.blank_n;
    assign box_x0       = pub_x0_q;
    assign box_x1       = pub_x1_q;
    assign box_y0       = pub_y0_q;
    assign box_y1       = pub_y1_q;
    assign match_count  = pub_cnt_q;
    assign detected     = pub_det_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_color_tracker.sv
module tb_color_tracker;

    localparam int W    = 10;
    localparam int H    = 10;
    localparam int MINC = 16;
    localparam int XW   = 4;
    localparam int YW   = 4;
    localparam int CW   = 7;
    localparam logic [23:0] RED   = 24'hC80000;
    localparam logic [23:0] NEARR = 24'hC86500;

    logic          VGA_CLK = 1'b0;
    logic          reset;
    logic [7:0]    iR, iG, iB;
    logic          iHS, iVS, iSYNC, iBN;
    logic [7:0]    r_min, g_max, b_max;
    logic          overlay_en;
    logic [7:0]    oR, oG, oB;
    logic          oHS, oVS, oSYNC, oBN;
    logic [XW-1:0] box_x0, box_x1;
    logic [YW-1:0] box_y0, box_y1;
    logic [CW-1:0] match_count;
    logic          detected, frame_done;

    color_tracker #(.WIDTH(W), .HEIGHT(H), .MIN_COUNT(MINC)) dut (
        .VGA_CLK(VGA_CLK), .reset(reset),
        .iVGA_R(iR), .iVGA_G(iG), .iVGA_B(iB),
        .iVGA_HS(iHS), .iVGA_VS(iVS), .iVGA_SYNC_N(iSYNC), .iVGA_BLANK_N(iBN),
        .r_min(r_min), .g_max(g_max), .b_max(b_max), .overlay_en(overlay_en),
        .oVGA_R(oR), .oVGA_G(oG), .oVGA_B(oB),
        .oVGA_HS(oHS), .oVGA_VS(oVS), .oVGA_SYNC_N(oSYNC), .oVGA_BLANK_N(oBN),
        .box_x0(box_x0), .box_x1(box_x1), .box_y0(box_y0), .box_y1(box_y1),
        .match_count(match_count), .detected(detected), .frame_done(frame_done)
    );

    always #20 VGA_CLK = ~VGA_CLK;

    typedef struct packed {
        logic [23:0] rgb;
        logic        hs, vs, sync_n, blank_n;
    } spx_t;

    typedef struct {
        int cnt;
        int det;
        int x0, x1, y0, y1;
    } res_t;

    spx_t sq[$];
    res_t rq[$];

    int checks   = 0;
    int failures = 0;
    int fd_seen  = 0;

    // Reference model state: per-frame statistics and the currently published result.
    int   m_cnt, m_minx, m_maxx, m_miny, m_maxy;
    bit   m_prev_vs, m_armed;
    res_t m_pub;

    logic [23:0] img [0:H-1][0:W];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_minx = 0; m_maxx = 0; m_miny = 0; m_maxy = 0;
        m_prev_vs = 1'b1;
        m_armed   = 1'b0;
        m_pub     = '{0, 0, 0, 0, 0, 0};
    endtask

    function automatic bit on_box(input int x, input int y);
        return ((x == m_pub.x0 || x == m_pub.x1) && y >= m_pub.y0 && y <= m_pub.y1) ||
               ((y == m_pub.y0 || y == m_pub.y1) && x >= m_pub.x0 && x <= m_pub.x1);
    endfunction

    task automatic drive_cycle(input logic [23:0] rgb, input logic hs, input logic vs,
                               input logic bn, input int x, input int y);
        spx_t e;
        res_t r;
        {iR, iG, iB} = rgb;
        iHS = hs; iVS = vs; iBN = bn;
        iSYNC = 1'($urandom_range(0, 1));
        e = '{rgb: rgb, hs: hs, vs: vs, sync_n: iSYNC, blank_n: bn};
        if (bn && overlay_en && m_pub.det != 0 && on_box(x, y)) e.rgb = 24'h00FF00;
        if (bn && x < W && y < H && rgb[23:16] >= r_min && rgb[15:8] <= g_max && rgb[7:0] <= b_max) begin
            if (m_cnt == 0) begin
                m_minx = x; m_maxx = x; m_miny = y; m_maxy = y;
            end else begin
                if (x < m_minx) m_minx = x;
                if (x > m_maxx) m_maxx = x;
                if (y < m_miny) m_miny = y;
                if (y > m_maxy) m_maxy = y;
            end
            if (m_cnt < (1 << CW) - 1) m_cnt++;
        end
        if (m_prev_vs && !vs) begin
            if (m_armed) begin
                r.cnt = m_cnt;
                r.det = (m_cnt >= MINC) ? 1 : 0;
                r.x0 = r.det != 0 ? m_minx : 0;
                r.x1 = r.det != 0 ? m_maxx : 0;
                r.y0 = r.det != 0 ? m_miny : 0;
                r.y1 = r.det != 0 ? m_maxy : 0;
                rq.push_back(r);
                m_pub = r;
            end
            m_armed = 1'b1;
            m_cnt = 0;
        end
        m_prev_vs = vs;
        @(posedge VGA_CLK);
        sq.push_back(e);
        #1;
    endtask

    // Vertical sync, back porch, HEIGHT lines of (W+extra) pixels with horizontal blanking.
    // Returns early halfway through line stop_line.
    task automatic drive_frame(input int extra, input int stop_line, input bit rnd_thr);
        for (int i = 0; i < 3; i++) drive_cycle(24'h0, 1'b1, 1'b0, 1'b0, -1, -1);
        for (int i = 0; i < 3; i++) drive_cycle(24'h0, 1'b1, 1'b1, 1'b0, -1, -1);
        for (int y = 0; y < H; y++) begin
            if (rnd_thr && y == H/2) r_min = 8'($urandom_range(120, 200));
            for (int x = 0; x < W + extra; x++) begin
                if (y == stop_line && x == W/2) return;
                drive_cycle(img[y][x], 1'b1, 1'b1, 1'b1, x, y);
            end
            drive_cycle(24'h0, 1'b1, 1'b1, 1'b0, -1, -1);
            drive_cycle(24'h0, 1'b0, 1'b1, 1'b0, -1, -1);
            drive_cycle(24'h0, 1'b0, 1'b1, 1'b0, -1, -1);
            drive_cycle(24'h0, 1'b1, 1'b1, 1'b0, -1, -1);
        end
        for (int i = 0; i < 2; i++) drive_cycle(24'h0, 1'b1, 1'b1, 1'b0, -1, -1);
    endtask

    task automatic fill_const(input logic [23:0] c);
        for (int y = 0; y < H; y++)
            for (int x = 0; x <= W; x++) img[y][x] = c;
    endtask

    task automatic fill_block(input int x0, input int x1, input int y0, input int y1);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++) img[y][x] = RED;
    endtask

    task automatic fill_random(input int pct);
        for (int y = 0; y < H; y++)
            for (int x = 0; x <= W; x++) begin
                if ($urandom_range(0, 99) < pct)
                    img[y][x] = {8'($urandom_range(180, 255)), 8'($urandom_range(0, 40)), 8'($urandom_range(0, 40))};
                else
                    img[y][x] = 24'($urandom);
            end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_hs"}, int'(oHS), 1);
        chk({tag, "_vs"}, int'(oVS), 1);
        chk({tag, "_rgb"}, int'({oR, oG, oB}), 0);
        chk({tag, "_sync_blank"}, int'({oSYNC, oBN}), 0);
        chk({tag, "_box"}, int'({box_x0, box_x1, box_y0, box_y1}), 0);
        chk({tag, "_count"}, int'(match_count), 0);
        chk({tag, "_det_done"}, int'({detected, frame_done}), 0);
    endtask

    spx_t mon_e, mon_a;
    res_t mon_r;

    always @(negedge VGA_CLK) begin
        if (!reset) begin
            if (sq.size() > 0) begin
                mon_e = sq.pop_front();
                mon_a = '{rgb: {oR, oG, oB}, hs: oHS, vs: oVS, sync_n: oSYNC, blank_n: oBN};
                checks++;
                if (mon_a !== mon_e) begin
                    failures++;
                    $display("FAIL stream actual=%h expected=%h", mon_a, mon_e);
                end
            end
            if (frame_done) begin
                fd_seen++;
                if (rq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL frame_done actual=1 expected=0 (no frame pending)");
                end else begin
                    mon_r = rq.pop_front();
                    chk("match_count", int'(match_count), mon_r.cnt);
                    chk("detected", int'(detected), mon_r.det);
                    chk("box_x0", int'(box_x0), mon_r.x0);
                    chk("box_x1", int'(box_x1), mon_r.x1);
                    chk("box_y0", int'(box_y0), mon_r.y0);
                    chk("box_y1", int'(box_y1), mon_r.y1);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        {iR, iG, iB} = 24'h0;
        iHS = 1'b1; iVS = 1'b1; iSYNC = 1'b0; iBN = 1'b0;
        r_min = 8'd155; g_max = 8'd100; b_max = 8'd100;
        overlay_en = 1'b0;
        model_reset();
        repeat (3) @(posedge VGA_CLK);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;

        // Arming frame: no result is published at its VS fall.
        fill_const(24'h0);
        drive_frame(0, H, 1'b0);
        chk("no_frame_done_after_arm", fd_seen, 0);

        // Red block plus a pixel that misses only on green by one.
        fill_const(24'h0);
        fill_block(2, 5, 3, 7);
        img[0][0] = NEARR;
        drive_frame(0, H, 1'b0);

        // Overlay of the block's box over noise; a single match at the far corner;
        // an 11th red pixel on every line that must never count.
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = {8'($urandom_range(0, 154)), 8'($urandom), 8'($urandom)};
        img[H-1][W-1] = RED;
        for (int y = 0; y < H; y++) img[y][W] = RED;
        overlay_en = 1'b1;
        drive_frame(1, H, 1'b0);
        overlay_en = 1'b0;

        fill_const(24'h0);
        fill_block(2, 5, 3, 7);
        img[H-1][W-1] = RED;
        drive_frame(0, H, 1'b0);

        for (int f = 0; f < 6; f++) begin
            r_min = 8'($urandom_range(120, 200));
            g_max = 8'($urandom_range(40, 120));
            b_max = 8'($urandom_range(40, 120));
            overlay_en = 1'($urandom_range(0, 1));
            fill_random($urandom_range(5, 35));
            drive_frame($urandom_range(0, 1), H, 1'b1);
        end

        // Reset in the middle of a line.
        overlay_en = 1'b0;
        r_min = 8'd155; g_max = 8'd100; b_max = 8'd100;
        fill_random(30);
        drive_frame(0, 4, 1'b0);
        #2 reset = 1'b1;
        #1;
        check_reset_outputs("midframe_reset");
        sq.delete();
        rq.delete();
        model_reset();
        {iR, iG, iB} = 24'h0;
        iHS = 1'b1; iVS = 1'b1; iBN = 1'b0;
        repeat (2) @(posedge VGA_CLK);
        #1 reset = 1'b0;

        fill_random(25);
        drive_frame(0, H, 1'b0);
        fill_const(24'h0);
        fill_block(2, 5, 3, 7);
        drive_frame(0, H, 1'b0);
        fill_const(24'h0);
        drive_frame(0, H, 1'b0);
        for (int i = 0; i < 4; i++) drive_cycle(24'h0, 1'b1, 1'b0, 1'b0, -1, -1);
        for (int i = 0; i < 4; i++) drive_cycle(24'h0, 1'b1, 1'b1, 1'b0, -1, -1);
        repeat (3) @(negedge VGA_CLK);

        chk("results_pending", rq.size(), 0);
        chk("frame_done_total", fd_seen, 13);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
